// File: rtl/video_color_pipe.sv
// video_color_pipe: pixel-rate colour mapping stage between the williams2 core
// and arcade_video. Generates the pixel clock enable, samples core video once
// per pixel, maps each channel through a shared {colour,intensity} LUT read
// over one single-port memory, and emits OW-bit RGB with timing delayed to match.
// Build option: define VCP_LUT_LOAD_EN for a runtime-loadable LUT (dn_* write
// handshake); otherwise the LUT is a ROM of the default ramp and dn_* is inert.
module video_color_pipe #(
  parameter int unsigned CW     = 4,
  parameter int unsigned IW     = 4,
  parameter int unsigned OW     = 8,
  parameter int unsigned CE_DIV = 8
) (
  input  logic             clk_video,
  input  logic             reset,
  input  logic [CW-1:0]    r_in,
  input  logic [CW-1:0]    g_in,
  input  logic [CW-1:0]    b_in,
  input  logic [IW-1:0]    i_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic             ce_pix,
  output logic [OW-1:0]    r_out,
  output logic [OW-1:0]    g_out,
  output logic [OW-1:0]    b_out,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             hs_out,
  output logic             vs_out,
  input  logic [CW+IW-1:0] dn_addr,
  input  logic [OW-1:0]    dn_data,
  input  logic             dn_wr,
  output logic             dn_ready,
  output logic             dn_ack
);

  localparam int unsigned AW        = CW + IW;
  localparam int unsigned LUT_DEPTH = 2 ** AW;
  localparam int unsigned DIV_W     = $clog2(CE_DIV);

  // The schedule needs three read slots plus a spare cycle before the output update.
  if (CE_DIV < 6) begin : g_bad_ce_div
    $error("video_color_pipe: CE_DIV must be >= 6");
  end

  // Which colour channel the single memory port is reading this cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RD_R,
    SLOT_RD_G,
    SLOT_RD_B
  } slot_e;

  typedef logic [OW-1:0] lut_t [LUT_DEPTH];

  // Default ramp: entry {c,i} = floor(c*i*(2^OW-1) / ((2^CW-1)*(2^IW-1))).
  function automatic logic [OW-1:0] lut_default(input logic [AW-1:0] a);
    longint unsigned c;
    longint unsigned i;
    longint unsigned num;
    longint unsigned den;
    c   = 64'(a[AW-1:IW]);
    i   = 64'(a[IW-1:0]);
    num = c * i * ((64'd1 << OW) - 64'd1);
    den = ((64'd1 << CW) - 64'd1) * ((64'd1 << IW) - 64'd1);
    return OW'(num / den);
  endfunction

  function automatic lut_t lut_defaults();
    lut_t t;
    for (int unsigned a = 0; a < LUT_DEPTH; a++) begin
      t[a] = lut_default(AW'(a));
    end
    return t;
  endfunction

  logic [DIV_W-1:0] r_div;
  logic             r_ce_pix;
  logic             w_last;

  logic [CW-1:0]    r_hold_r;
  logic [CW-1:0]    r_hold_g;
  logic [CW-1:0]    r_hold_b;
  logic [IW-1:0]    r_hold_i;
  logic             r_hold_hb;
  logic             r_hold_vb;
  logic             r_hold_hs;
  logic             r_hold_vs;

  slot_e            w_slot;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic [OW-1:0]    r_lut_q;
  logic [OW-1:0]    r_lut_r;
  logic [OW-1:0]    r_lut_g;
  logic [OW-1:0]    r_lut_b;
  logic             w_force;

  logic [OW-1:0]    r_out_r;
  logic [OW-1:0]    r_out_g;
  logic [OW-1:0]    r_out_b;
  logic             r_out_hb;
  logic             r_out_vb;
  logic             r_out_hs;
  logic             r_out_vs;

  assign w_last = (r_div == DIV_W'(CE_DIV - 1));

  // Pixel divider; ce_pix is registered so it is high while div==0.
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_ce_pix <= 1'b0;
    end else begin
      r_ce_pix <= w_last;
      r_div    <= w_last ? '0 : r_div + DIV_W'(1);
    end
  end

  // Sample core video once per pixel; changes between samples are ignored.
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      r_hold_r  <= '0;
      r_hold_g  <= '0;
      r_hold_b  <= '0;
      r_hold_i  <= '0;
      r_hold_hb <= 1'b0;
      r_hold_vb <= 1'b0;
      r_hold_hs <= 1'b0;
      r_hold_vs <= 1'b0;
    end else if (r_div == '0) begin
      r_hold_r  <= r_in;
      r_hold_g  <= g_in;
      r_hold_b  <= b_in;
      r_hold_i  <= i_in;
      r_hold_hb <= hblank_in;
      r_hold_vb <= vblank_in;
      r_hold_hs <= hs_in;
      r_hold_vs <= vs_in;
    end
  end

  // Read-slot decode: div 1/2/3 read R/G/B entries from the held pixel.
  always_comb begin
    w_slot    = SLOT_IDLE;
    w_rd_addr = {r_hold_r, r_hold_i};
    if (r_div == DIV_W'(1)) begin
      w_slot    = SLOT_RD_R;
      w_rd_addr = {r_hold_r, r_hold_i};
    end else if (r_div == DIV_W'(2)) begin
      w_slot    = SLOT_RD_G;
      w_rd_addr = {r_hold_g, r_hold_i};
    end else if (r_div == DIV_W'(3)) begin
      w_slot    = SLOT_RD_B;
      w_rd_addr = {r_hold_b, r_hold_i};
    end
  end

  assign w_rd_en = (w_slot != SLOT_IDLE);

`ifdef VCP_LUT_LOAD_EN
  lut_t             r_lut = lut_defaults();
  logic             r_pend_valid;
  logic [AW-1:0]    r_pend_addr;
  logic [OW-1:0]    r_pend_data;
  logic             w_commit;

  // A pending write only touches the memory outside the read slots, so a
  // pixel's three reads always see one consistent LUT image.
  assign w_commit = r_pend_valid && (w_slot == SLOT_IDLE);

  // Pending-write register; reset discards an uncommitted write.
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
    end else if (w_commit) begin
      r_pend_valid <= 1'b0;
    end else if (dn_wr && !r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= dn_addr;
      r_pend_data  <= dn_data;
    end
  end

  // Single-port LUT: write on commit, synchronous read in the read slots.
  always_ff @(posedge clk_video) begin
    if (w_commit) begin
      r_lut[r_pend_addr] <= r_pend_data;
    end
    if (w_rd_en) begin
      r_lut_q <= r_lut[w_rd_addr];
    end
  end

  assign dn_ready = ~r_pend_valid;
  assign dn_ack   = w_commit;
`else
  logic w_dn_unused;

  assign w_dn_unused = ^{dn_addr, dn_data, dn_wr};

  // Fixed ramp ROM with the same one-cycle read latency as the RAM build.
  always_ff @(posedge clk_video) begin
    if (w_rd_en) begin
      r_lut_q <= lut_default(w_rd_addr);
    end
  end

  assign dn_ready = 1'b0;
  assign dn_ack   = 1'b0;
`endif

  // Collect LUT data one cycle after each read slot (div 2/3/4).
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      r_lut_r <= '0;
      r_lut_g <= '0;
      r_lut_b <= '0;
    end else begin
      if (r_div == DIV_W'(2)) r_lut_r <= r_lut_q;
      if (r_div == DIV_W'(3)) r_lut_g <= r_lut_q;
      if (r_div == DIV_W'(4)) r_lut_b <= r_lut_q;
    end
  end

  assign w_force = (r_hold_i == '0) | r_hold_hb | r_hold_vb;

  // Update colour and timing together on the edge that starts the next ce_pix.
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      r_out_r  <= '0;
      r_out_g  <= '0;
      r_out_b  <= '0;
      r_out_hb <= 1'b0;
      r_out_vb <= 1'b0;
      r_out_hs <= 1'b0;
      r_out_vs <= 1'b0;
    end else if (w_last) begin
      r_out_r  <= w_force ? '0 : r_lut_r;
      r_out_g  <= w_force ? '0 : r_lut_g;
      r_out_b  <= w_force ? '0 : r_lut_b;
      r_out_hb <= r_hold_hb;
      r_out_vb <= r_hold_vb;
      r_out_hs <= r_hold_hs;
      r_out_vs <= r_hold_vs;
    end
  end

  assign ce_pix     = r_ce_pix;
  assign r_out      = r_out_r;
  assign g_out      = r_out_g;
  assign b_out      = r_out_b;
  assign hblank_out = r_out_hb;
  assign vblank_out = r_out_vb;
  assign hs_out     = r_out_hs;
  assign vs_out     = r_out_vs;

endmodule

// File: tb/tb_video_color_pipe.sv
// Testbench for video_color_pipe: directed and random pixels checked against a
// pixel-level model (LUT array + forcing rule + one-pixel delay).
// Honours VCP_LUT_LOAD_EN to select write-handshake expectations.
module tb_video_color_pipe;

  localparam int unsigned CW     = 4;
  localparam int unsigned IW     = 4;
  localparam int unsigned OW     = 8;
  localparam int unsigned CE_DIV = 8;
  localparam int unsigned AW     = CW + IW;
  localparam int unsigned BW     = 3 * OW + 4;

  logic          clk_video = 1'b0;
  logic          reset;
  logic [CW-1:0] r_in, g_in, b_in;
  logic [IW-1:0] i_in;
  logic          hblank_in, vblank_in, hs_in, vs_in;
  logic          ce_pix;
  logic [OW-1:0] r_out, g_out, b_out;
  logic          hblank_out, vblank_out, hs_out, vs_out;
  logic [AW-1:0] dn_addr;
  logic [OW-1:0] dn_data;
  logic          dn_wr;
  logic          dn_ready, dn_ack;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   cyc   = 0;
  logic [BW-1:0] exp_prev;
  logic [OW-1:0] lut_model [2**AW];

  always #5 clk_video = ~clk_video;

  video_color_pipe #(
    .CW(CW), .IW(IW), .OW(OW), .CE_DIV(CE_DIV)
  ) dut (
    .clk_video(clk_video), .reset(reset),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .i_in(i_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hs_in(hs_in), .vs_in(vs_in),
    .ce_pix(ce_pix),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out), .hs_out(hs_out), .vs_out(vs_out),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .dn_ready(dn_ready), .dn_ack(dn_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] outs();
    return {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out};
  endfunction

  function automatic logic [BW-1:0] expect_pix(input logic [CW-1:0] pr, pg, pb,
                                               input logic [IW-1:0] pi,
                                               input logic hb, vb, hs, vs);
    logic [OW-1:0] er, eg, eb;
    logic blank;
    blank = (pi == '0) || hb || vb;
    er = blank ? '0 : lut_model[{pr, pi}];
    eg = blank ? '0 : lut_model[{pg, pi}];
    eb = blank ? '0 : lut_model[{pb, pi}];
    return {er, eg, eb, hb, vb, hs, vs};
  endfunction

  task automatic tick();
    @(posedge clk_video);
    #1;
    cyc++;
    check("ce_pix", 32'(ce_pix), 32'((cyc % CE_DIV == 0) && (cyc != 0)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"}, 32'(outs()), 32'(0));
    check({tag, "_ce"}, 32'(ce_pix), 32'(0));
    check({tag, "_ack"}, 32'(dn_ack), 32'(0));
`ifdef VCP_LUT_LOAD_EN
    check({tag, "_ready"}, 32'(dn_ready), 32'(1));
`else
    check({tag, "_ready"}, 32'(dn_ready), 32'(0));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_state("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_video);
      #1;
      check_reset_state("rst_hold");
    end
    reset    = 1'b0;
    cyc      = 0;
    exp_prev = '0;
  endtask

  // Entered at the sample point of a div==0 cycle; leaves at the next one.
  // wr_div==1 issues the 0xFF<-0x5A write in the div 1 cycle; drop_div issues
  // a second write that must be ignored because one is already pending.
  task automatic run_pixel(input logic [CW-1:0] pr, pg, pb, input logic [IW-1:0] pi,
                           input logic hb, vb, hs, vs, input int wr_div, input int drop_div);
    logic [BW-1:0] exp_new;
    exp_new   = expect_pix(pr, pg, pb, pi, hb, vb, hs, vs);
    r_in      = pr;
    g_in      = pg;
    b_in      = pb;
    i_in      = pi;
    hblank_in = hb;
    vblank_in = vb;
    hs_in     = hs;
    vs_in     = vs;
    for (int s = 0; s < int'(CE_DIV); s++) begin
      dn_wr   = (s == wr_div) || (s == drop_div);
      dn_addr = 8'hFF;
      dn_data = (s == drop_div) ? 8'h11 : 8'h5A;
      if (s == 1) begin
        r_in      = CW'($urandom);
        g_in      = CW'($urandom);
        b_in      = CW'($urandom);
        i_in      = IW'($urandom);
        hblank_in = 1'($urandom);
        vblank_in = 1'($urandom);
        hs_in     = 1'($urandom);
        vs_in     = 1'($urandom);
      end
      tick();
      if (s + 1 < int'(CE_DIV)) check("out_hold", 32'(outs()), 32'(exp_prev));
      else                      check("out_new", 32'(outs()), 32'(exp_new));
`ifdef VCP_LUT_LOAD_EN
      check("dn_ack", 32'(dn_ack), 32'(wr_div == 1 && s + 1 == 4));
      check("dn_ready", 32'(dn_ready), 32'(!(wr_div == 1 && s + 1 >= 2 && s + 1 <= 4)));
`else
      check("dn_ack", 32'(dn_ack), 32'(0));
      check("dn_ready", 32'(dn_ready), 32'(0));
`endif
    end
    dn_wr = 1'b0;
`ifdef VCP_LUT_LOAD_EN
    if (wr_div == 1) lut_model[8'hFF] = 8'h5A;
`endif
    exp_prev = exp_new;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned a = 0; a < 2**AW; a++) begin
      int unsigned c, i;
      c = a / (1 << IW);
      i = a % (1 << IW);
      lut_model[a] = OW'((c * i * ((1 << OW) - 1)) / (((1 << CW) - 1) * ((1 << IW) - 1)));
    end
    r_in = '0; g_in = '0; b_in = '0; i_in = '0;
    hblank_in = 1'b0; vblank_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    dn_addr = '0; dn_data = '0; dn_wr = 1'b0;
    exp_prev = '0;
    #2;
    do_reset();

    // Default ramp values, first pixel also checks outputs stay 0 until the update edge.
    run_pixel(4'd15, 4'd1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    check("r_15_15", 32'(r_out), 32'd255);
    check("g_1_15", 32'(g_out), 32'd17);
    run_pixel(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    check("b_8_8", 32'(b_out), 32'd72);

    // Forcing: zero intensity, then hblank with full colour.
    run_pixel(4'd15, 4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    check("force_i0", 32'(r_out), 32'd0);
    run_pixel(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    check("force_hb", 32'({r_out, hblank_out}), 32'({8'd0, 1'b1}));

    // vs pulse travels with its pixel's colour.
    run_pixel(4'd5, 4'd6, 4'd7, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    check("vs_align", 32'({r_out, vs_out}), 32'({8'd51, 1'b1}));
    run_pixel(4'd5, 4'd6, 4'd7, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    check("vs_drop", 32'(vs_out), 32'(0));

    // Write 0xFF<-0x5A during a pixel that reads 0xFF, plus a dropped second write.
    run_pixel(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2);
    check("wr_hazard_old", 32'(r_out), 32'd255);
    run_pixel(4'd15, 4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
`ifdef VCP_LUT_LOAD_EN
    check("wr_new", 32'(r_out), 32'h5A);
`else
    check("rom_ignores_wr", 32'(r_out), 32'hFF);
`endif

    // Reset with a write pending to entry 0x88, partway through a pixel.
    dn_wr = 1'b1; dn_addr = 8'h88; dn_data = 8'hC3;
    tick();
    dn_wr = 1'b0;
    check("pend_out_hold", 32'(outs()), 32'(exp_prev));
`ifdef VCP_LUT_LOAD_EN
    check("pend_ready", 32'(dn_ready), 32'(0));
`endif
    tick();
    do_reset();
    run_pixel(4'd8, 4'd8, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    check("rst_lut_kept", 32'(r_out), 32'd72);

    // Random pixels.
    for (int n = 0; n < 40; n++) begin
      run_pixel(CW'($urandom), CW'($urandom), CW'($urandom), IW'($urandom),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom), 1'($urandom), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_color_pipe.md
Name: video_color_pipe

Overview:
- Parametrised successor to the fixed 4-bit RGB + 4-bit intensity palette stage in the Williams-2 top level.
- Generates the pixel clock enable and samples core video once per pixel.
- Maps each colour channel through a shared {colour,intensity} LUT and outputs OW-bit RGB with blank and sync delayed to match.
- Sits between the williams2 core outputs and arcade_video. The LUT is runtime-loadable from the download bus; reads are time-multiplexed over one single-port RAM.

Parameters:
CW, 4, colour channel input width
IW, 4, intensity input width
OW, 8, output channel width
CE_DIV, 8, video clocks per pixel. Must be >= 6; a smaller value is an elaboration error.

Ports:
clk_video  in  1  video clock (48 MHz in Joust2)
reset  in  1  asynchronous, active-high
r_in, g_in, b_in  in  CW each  core colour
i_in  in  IW  core intensity
hblank_in, vblank_in, hs_in, vs_in  in  1 each  core timing, active-high
ce_pix  out  1  pixel enable, one clk_video cycle in every CE_DIV
r_out, g_out, b_out  out  OW each  mapped colour
hblank_out, vblank_out, hs_out, vs_out  out  1 each  delayed timing
dn_addr  in  CW+IW  LUT write address {colour,intensity}
dn_data  in  OW  LUT write data
dn_wr  in  1  write strobe, one cycle
dn_ready  out  1  high when a new write is accepted
dn_ack  out  1  one-cycle pulse when a write is committed to the LUT

Behaviour:
- Reset (async) values:
  - div=0, ce_pix=0, all colour/timing outputs 0.
  - dn_ready=1, dn_ack=0, pending write cleared.
  - LUT contents are not reset.
- Divider:
  - div counts 0..CE_DIV-1 and wraps to 0.
  - ce_pix is registered and is high during the cycle in which div==0.
- Slot schedule, per pixel (div value at the clock edge):
  - div 0: capture r/g/b/i_in and the four timing inputs into hold registers.
  - div 1, 2, 3: LUT read addresses {r,i}, {g,i}, {b,i}.
  - The synchronous RAM returns data one cycle later; R, G, B are captured at div 2, 3, 4.
  - div CE_DIV-1: update all output registers together.
- Latency: outputs change on the edge that starts the next ce_pix cycle, one pixel after sampling. r/g/b and timing outputs always change on the same edge.
- Output forcing: an output channel is 0 if captured intensity==0 or captured (hblank|vblank)==1, regardless of LUT content.
- LUT default content (initial): entry {c,i} = floor(c*i*(2^OW-1) / ((2^CW-1)*(2^IW-1))).
- Write handshake:
  - dn_wr with dn_ready=1 latches addr/data into a pending register; dn_ready drops on the next cycle.
  - The commit happens in the first cycle whose div is not in {1,2,3}.
  - On commit, dn_ack pulses for one cycle and dn_ready returns to 1 on the following cycle.
  - dn_wr while dn_ready=0 is dropped with no ack.
  - Worst-case accept-to-ack latency is 4 cycles.
- Read/write hazard: a write committed after a read slot affects only later pixels. A read never observes a partially completed write.
- Reset mid-write: the pending write is discarded and no dn_ack is issued. Mid-pixel reset restarts the schedule at div=0.
- Input changes between div 0 samples are ignored.

Optional Feature:
VCP_LUT_LOAD_EN
- Defined: LUT is RAM, and the dn_* handshake operates as specified above.
- Undefined: LUT is ROM holding the default content. dn_addr, dn_data and dn_wr are ignored; dn_ready and dn_ack are tied 0. Read timing and latency are unchanged.

Test Plan:
- Reset release, CE_DIV=8: ce_pix period is 8 cycles, first high at the cycle where div==0; all outputs 0 until the first output-update edge.
- Default LUT:
  - r=15,i=15 -> 255
  - g=1,i=15 -> 17
  - b=8,i=8 -> 72
  - Each value appears at the edge before the next ce_pix.
- Forcing: r=15,i=0 -> r_out=0; r=15,i=15 with hblank_in=1 -> r_out=0 and hblank_out=1, both on the same edge.
- (VCP_LUT_LOAD_EN) dn_wr addr 0xFF, data 0x5A at div=1:
  - dn_ready falls next cycle.
  - dn_ack pulses at div 4.
  - Next pixel with r=15,i=15 -> r_out=0x5A.
  - A second dn_wr issued while pending is dropped (no ack, LUT unchanged).
- Reset asserted with a write pending: no dn_ack; after release dn_ready=1, the LUT entry is unchanged, and the divider restarts from 0.
- Timing alignment: a vs_in pulse at pixel N appears on vs_out aligned with the colour of pixel N, one pixel (CE_DIV cycles) later.
